v_mul_scheduler: RTL and testbench

- Shares one vector multiplier datapath (Vedic multiplier core followed by output control) between two requesters.
- Arbitrates round-robin and launches one operation per cycle into the datapath.
- Tracks each in-flight operation's owner through the fixed datapath latency.
- Buffers results in a credit-protected FIFO and returns them in order over a valid/ready interface, tagged with the source requester.

---
 rtl/v_mul_pkg.sv | 34 +++
 rtl/v_mul_result_fifo.sv | 66 ++++++
 rtl/v_mul_scheduler.sv | 151 +++++++++++++++
 tb/tb_v_mul_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_mul_pkg.sv
// Shared types for the vector multiplier scheduler: request/response payloads and
// the opcode/precision encodings carried to the datapath.
package v_mul_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULH  = 2'b01,
    MULHU = 2'b10,
    MULSU = 2'b11
  } opcode_e;

  // 2'b11 is reserved; the datapath treats it as 8-bit lanes
  typedef enum logic [1:0] {
    P8     = 2'b00,
    P16    = 2'b01,
    P32    = 2'b10,
    P8_ALT = 2'b11
  } precision_e;

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    opcode_e           opcode;
    precision_e        precision;
  } mul_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              src;
  } mul_rsp_t;

endpackage

// File: rtl/v_mul_result_fifo.sv
// Register-based result FIFO; push and pop in the same cycle are legal when full or empty.
module v_mul_result_fifo
  import v_mul_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  mul_rsp_t      data_i,
  input  logic          pop_i,
  output mul_rsp_t      data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mul_rsp_t          mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop   = pop_i & (cnt_q != '0);
    do_push  = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Credits are reserved at accept, so a push can never land on a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/v_mul_scheduler.sv
// Two-requester round-robin front end for a shared fixed-latency multiplier datapath,
// with owner tracking and credit-protected in-order result return.
module v_mul_scheduler
  import v_mul_pkg::*;
#(
  parameter int unsigned DP_LATENCY = 2,
  parameter int unsigned OUT_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_op_a,
  input  logic [DATA_W-1:0] s0_op_b,
  input  logic [1:0]        s0_opcode,
  input  logic [1:0]        s0_precision,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_op_a,
  input  logic [DATA_W-1:0] s1_op_b,
  input  logic [1:0]        s1_opcode,
  input  logic [1:0]        s1_precision,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_op_a,
  output logic [DATA_W-1:0] dp_op_b,
  output logic [1:0]        dp_opcode,
  output logic [1:0]        dp_precision,
  input  logic [DATA_W-1:0] dp_result,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_result,
  output logic              m_src
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dp_valid_q, dp_valid_d;
  logic             dp_src_q, dp_src_d;
  mul_req_t         dp_req_q, dp_req_d;
  mul_req_t         req0, req1;
  logic             grant0, grant1, can_issue, accept, pop;
  logic             tag_valid, tag_src;
  mul_rsp_t         fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;

  assign req0 = '{op_a: s0_op_a, op_b: s0_op_b,
                  opcode: opcode_e'(s0_opcode), precision: precision_e'(s0_precision)};
  assign req1 = '{op_a: s1_op_a, op_b: s1_op_b,
                  opcode: opcode_e'(s1_opcode), precision: precision_e'(s1_precision)};

  // Arbitration; a pop in the same cycle frees a credit so a full pipe still streams
  always_comb begin
    grant0    = s0_valid & (~s1_valid | ~rr_q);
    grant1    = s1_valid & (~s0_valid | rr_q);
    pop       = m_valid & m_ready;
    can_issue = (cnt_q < CNT_W'(OUT_DEPTH)) | pop;
    s0_ready  = ~rst & can_issue & grant0;
    s1_ready  = ~rst & can_issue & grant1;
    accept    = s0_ready | s1_ready;
  end

  always_comb begin
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    dp_valid_d = accept;
    dp_req_d   = dp_req_q;
    dp_src_d   = dp_src_q;
    if (accept) begin
      rr_d     = ~s1_ready;
      dp_req_d = s1_ready ? req1 : req0;
      dp_src_d = s1_ready;
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_src_q   <= 1'b0;
      dp_req_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_src_q   <= dp_src_d;
      dp_req_q   <= dp_req_d;
    end
  end

  // Owner tag travels alongside the datapath so it lines up with dp_result
  if (DP_LATENCY == 0) begin : g_no_pipe
    assign tag_valid = dp_valid_q;
    assign tag_src   = dp_src_q;
  end else begin : g_pipe
    logic [DP_LATENCY-1:0] vld_q;
    logic [DP_LATENCY-1:0] src_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        src_q <= '0;
      end else begin
        vld_q[0] <= dp_valid_q;
        src_q[0] <= dp_src_q;
        for (int unsigned i = 1; i < DP_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          src_q[i] <= src_q[i-1];
        end
      end
    end
    assign tag_valid = vld_q[DP_LATENCY-1];
    assign tag_src   = src_q[DP_LATENCY-1];
  end

  assign fifo_din = '{result: dp_result, src: tag_src};

  v_mul_result_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_valid),
    .data_i  (fifo_din),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign dp_valid     = dp_valid_q;
  assign dp_op_a      = dp_req_q.op_a;
  assign dp_op_b      = dp_req_q.op_b;
  assign dp_opcode    = dp_req_q.opcode;
  assign dp_precision = dp_req_q.precision;
  assign m_valid      = ~fifo_empty;
  assign m_result     = fifo_dout.result;
  assign m_src        = fifo_dout.src;

  // Buffered results are always covered by outstanding credits
  a_credit_cover: assert property (@(posedge clk) disable iff (rst) fifo_cnt <= cnt_q);
  a_full_credit:  assert property (@(posedge clk) disable iff (rst)
                                   !fifo_full || (cnt_q == CNT_W'(OUT_DEPTH)));

endmodule

// File: tb/tb_v_mul_scheduler.sv
// Directed bench for v_mul_scheduler: per-cycle vector table plus hand sequences for
// backpressure, full streaming, reset mid-flight and a zero-latency/depth-2 instance.
module tb_v_mul_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [31:0] s0_op_a, s0_op_b, s1_op_a, s1_op_b;
  logic [1:0]  s0_opcode, s0_precision, s1_opcode, s1_precision;
  logic        dp_valid;
  logic [31:0] dp_op_a, dp_op_b, dp_result;
  logic [1:0]  dp_opcode, dp_precision;
  logic        m_valid, m_ready, m_src;
  logic [31:0] m_result;

  logic        b_s0_valid, b_s0_ready, b_s1_valid, b_s1_ready;
  logic [31:0] b_s0_op_a, b_s0_op_b, b_s1_op_a, b_s1_op_b;
  logic [1:0]  b_s0_opcode, b_s0_precision, b_s1_opcode, b_s1_precision;
  logic        b_dp_valid;
  logic [31:0] b_dp_op_a, b_dp_op_b, b_dp_result;
  logic [1:0]  b_dp_opcode, b_dp_precision;
  logic        b_m_valid, b_m_ready, b_m_src;
  logic [31:0] b_m_result;

  int n_chk = 0;
  int n_err = 0;
  int nacc  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  v_mul_scheduler dut_a (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_op_a(s0_op_a), .s0_op_b(s0_op_b),
    .s0_opcode(s0_opcode), .s0_precision(s0_precision),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_op_a(s1_op_a), .s1_op_b(s1_op_b),
    .s1_opcode(s1_opcode), .s1_precision(s1_precision),
    .dp_valid(dp_valid), .dp_op_a(dp_op_a), .dp_op_b(dp_op_b),
    .dp_opcode(dp_opcode), .dp_precision(dp_precision), .dp_result(dp_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_src(m_src)
  );

  v_mul_scheduler #(.DP_LATENCY(0), .OUT_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst),
    .s0_valid(b_s0_valid), .s0_ready(b_s0_ready), .s0_op_a(b_s0_op_a), .s0_op_b(b_s0_op_b),
    .s0_opcode(b_s0_opcode), .s0_precision(b_s0_precision),
    .s1_valid(b_s1_valid), .s1_ready(b_s1_ready), .s1_op_a(b_s1_op_a), .s1_op_b(b_s1_op_b),
    .s1_opcode(b_s1_opcode), .s1_precision(b_s1_precision),
    .dp_valid(b_dp_valid), .dp_op_a(b_dp_op_a), .dp_op_b(b_dp_op_b),
    .dp_opcode(b_dp_opcode), .dp_precision(b_dp_precision), .dp_result(b_dp_result),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_result(b_m_result), .m_src(b_m_src)
  );

  // Lane-wise low-half product model of the datapath
  function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] prec);
    logic [31:0] r;
    r = '0;
    case (prec)
      2'b01:   for (int i = 0; i < 2; i++) r[16*i +: 16] = 16'(a[16*i +: 16] * b[16*i +: 16]);
      2'b10:   r = 32'(a * b);
      default: for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(a[8*i +: 8] * b[8*i +: 8]);
    endcase
    return r;
  endfunction

  logic [31:0] st1, st2;
  always @(posedge clk) begin
    st1 <= dp_model(dp_op_a, dp_op_b, dp_precision);
    st2 <= st1;
  end
  assign dp_result   = st2;
  assign b_dp_result = dp_model(b_dp_op_a, b_dp_op_b, b_dp_precision);

  typedef struct {
    logic        rst, v0;
    logic [31:0] a0;
    logic        v1, mr;
    logic        r0, r1, dpv, mv, chk;
    logic [31:0] mres;
    logic        msrc;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic r, input logic v0, input logic [31:0] a0,
                              input logic v1, input logic mr, input logic r0, input logic r1,
                              input logic dpv, input logic mv, input logic c,
                              input logic [31:0] mres, input logic msrc);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.v1 = v1; v.mr = mr;
    v.r0 = r0; v.r1 = r1; v.dpv = dpv; v.mv = mv; v.chk = c; v.mres = mres; v.msrc = msrc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
    b_s0_valid = 1'b0; b_m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One s1 cycle of the backpressure/stream sequences with a result scoreboard
  task automatic sb_step(input logic v, input logic mr, input string tag,
                         input logic chk_rdy, input logic exp_rdy, input logic chk_mv);
    s1_valid = v; m_ready = mr;
    s1_op_a = {4{8'(nacc + 1)}};
    s1_op_b = 32'h03030303;
    @(negedge clk);
    if (chk_rdy) chk({tag, " s1_ready"}, s1_ready, exp_rdy);
    if (chk_mv)  chk({tag, " m_valid"}, m_valid, 1'b1);
    if (m_valid) begin
      if (exp_q.size() == 0) chk({tag, " unexpected result"}, 1'b1, 1'b0);
      else begin
        chk({tag, " m_result"}, m_result, exp_q[0]);
        chk({tag, " m_src"}, m_src, 1'b1);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
    if (s1_ready) begin
      exp_q.push_back({4{8'(3 * (nacc + 1))}});
      nacc++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    s0_valid = 0; s1_valid = 0; m_ready = 0;
    s0_op_a = 0; s0_op_b = 0; s0_opcode = 0; s0_precision = 0;
    s1_op_a = 0; s1_op_b = 0; s1_opcode = 0; s1_precision = 0;
    b_s0_valid = 0; b_s1_valid = 0; b_m_ready = 0;
    b_s0_op_a = 0; b_s0_op_b = 0; b_s0_opcode = 0; b_s0_precision = 0;
    b_s1_op_a = 0; b_s1_op_b = 0; b_s1_opcode = 0; b_s1_precision = 0;

    vt[0]  = mk(0, 1, 32'h02030405, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0);
    vt[1]  = mk(0, 0, 32'h02030405, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
    vt[2]  = mk(0, 0, 32'h02030405, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    vt[3]  = mk(0, 0, 32'h02030405, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    vt[4]  = mk(0, 0, 32'h02030405, 0, 1, 0, 0, 0, 1, 1, 32'h06090C0F, 0);
    vt[5]  = mk(0, 0, 32'h02030405, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
    vt[6]  = mk(1, 0, 32'h02030405, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    vt[7]  = mk(0, 1, 32'h01010101, 1, 1, 1, 0, 0, 0, 1, 32'h0, 0);
    vt[8]  = mk(0, 1, 32'h01010101, 1, 1, 0, 1, 1, 0, 0, 32'h0, 0);
    vt[9]  = mk(0, 1, 32'h01010101, 1, 1, 1, 0, 1, 0, 0, 32'h0, 0);
    vt[10] = mk(0, 1, 32'h01010101, 1, 1, 0, 1, 1, 0, 0, 32'h0, 0);
    vt[11] = mk(0, 1, 32'h01010101, 1, 1, 1, 0, 1, 1, 1, 32'h03030303, 0);
    vt[12] = mk(0, 1, 32'h01010101, 1, 1, 0, 1, 1, 1, 1, 32'h06060606, 1);
    vt[13] = mk(0, 0, 32'h01010101, 0, 1, 0, 0, 1, 1, 1, 32'h03030303, 0);
    vt[14] = mk(0, 0, 32'h01010101, 0, 1, 0, 0, 0, 1, 1, 32'h06060606, 1);
    vt[15] = mk(0, 0, 32'h01010101, 0, 1, 0, 0, 0, 1, 1, 32'h03030303, 0);
    vt[16] = mk(0, 0, 32'h01010101, 0, 1, 0, 0, 0, 1, 1, 32'h06060606, 1);
    vt[17] = mk(0, 0, 32'h01010101, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset s0_ready", s0_ready, 0);
    chk("reset s1_ready", s1_ready, 0);
    chk("reset dp_valid", dp_valid, 0);
    chk("reset dp_op_a", dp_op_a, 0);
    chk("reset dp_opcode", dp_opcode, 0);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_result", m_result, 0);
    chk("reset m_src", m_src, 0);
    chk("reset b_m_valid", b_m_valid, 0);
    @(posedge clk); #1;

    // Single op, reset, then round-robin contention
    for (int i = 0; i < 18; i++) begin
      rst = vt[i].rst;
      s0_valid = vt[i].v0; s0_op_a = vt[i].a0; s0_op_b = 32'h03030303;
      s1_valid = vt[i].v1; s1_op_a = 32'h02020202; s1_op_b = 32'h03030303;
      m_ready = vt[i].mr;
      @(negedge clk);
      chk($sformatf("row%0d s0_ready", i), s0_ready, vt[i].r0);
      chk($sformatf("row%0d s1_ready", i), s1_ready, vt[i].r1);
      chk($sformatf("row%0d dp_valid", i), dp_valid, vt[i].dpv);
      chk($sformatf("row%0d m_valid", i), m_valid, vt[i].mv);
      if (vt[i].chk) begin
        chk($sformatf("row%0d m_result", i), m_result, vt[i].mres);
        chk($sformatf("row%0d m_src", i), m_src, vt[i].msrc);
      end
      if (i == 1) chk("row1 dp_op_a", dp_op_a, 32'h02030405);
      @(posedge clk); #1;
    end

    // Backpressure, one-cycle release, full streaming, drain
    do_reset();
    for (int i = 0; i < 12; i++)
      sb_step(1'b1, (i == 8), $sformatf("bp%0d", i), 1'b1, (i < 4) || (i == 8), (i >= 4));
    chk("bp accepts", nacc, 5);
    for (int i = 0; i < 8; i++)
      sb_step(1'b1, 1'b1, $sformatf("full%0d", i), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      sb_step(1'b0, 1'b1, $sformatf("drain%0d", i), 1'b0, 1'b0, 1'b0);
    chk("drain leftover", exp_q.size(), 0);
    chk("drain m_valid", m_valid, 0);

    // Reset with three ops in flight
    do_reset();
    s0_opcode = 2'b10; s0_precision = 2'b01; s0_op_b = 32'h0A0B0C0D;
    for (int i = 0; i < 3; i++) begin
      s0_valid = 1'b1; s0_op_a = 32'h11223340 + i; m_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("inflight%0d s0_ready", i), s0_ready, 1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("in-reset s0_ready", s0_ready, 0);
    chk("in-reset s1_ready", s1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; s0_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset%0d m_valid", i), m_valid, 0);
      if (i == 0) begin
        chk("post-reset dp_valid", dp_valid, 0);
        chk("post-reset dp_op_a", dp_op_a, 0);
        chk("post-reset dp_op_b", dp_op_b, 0);
        chk("post-reset dp_opcode", dp_opcode, 0);
        chk("post-reset dp_precision", dp_precision, 0);
        chk("post-reset m_result", m_result, 0);
        chk("post-reset m_src", m_src, 0);
      end
      @(posedge clk); #1;
    end
    s0_valid = 1'b1; s1_valid = 1'b1; s0_opcode = 0; s0_precision = 0;
    @(negedge clk);
    chk("post-reset grant s0", s0_ready, 1);
    chk("post-reset grant s1", s1_ready, 0);
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0;

    // Zero-latency datapath with depth-2 FIFO, s0 back-to-back
    do_reset();
    begin
      int kb;
      kb = 0;
      for (int i = 0; i < 10; i++) begin
        b_s0_valid = (i < 6);
        b_s0_op_a = {4{8'(kb + 5)}};
        b_s0_op_b = 32'h02020202;
        b_m_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("lat0 %0d s0_ready", i), b_s0_ready, (i < 6));
        chk($sformatf("lat0 %0d m_valid", i), b_m_valid, (i >= 2) && (i < 8));
        if ((i >= 2) && (i < 8)) begin
          chk($sformatf("lat0 %0d m_result", i), b_m_result, {4{8'(2 * i + 6)}});
          chk($sformatf("lat0 %0d m_src", i), b_m_src, 0);
        end
        if (b_s0_ready) kb++;
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
